id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the LC-3 pipeline, directly downstream of the fetch stage. It registers the fetched instruction word and its PC and decodes opcode, register and immediate fields. It reads operands from an internal 8x16 register file with write-through bypass from the writeback port. It detects load-use hazards and drives a stall to fetch, and presents a registered decode bundle to the execute stage.

## Interface
- No parameters. Data width is fixed at 16 bits; there are 8 registers.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- pause  in  1  downstream hold; all output registers keep their value
- flush  in  1  taken branch/jump; next output is a bubble
- idIR  in  16  instruction word from fetch
- idNPC  in  16  PC+1 of that instruction from fetch
- wbEn  in  1  register-file write enable
- wbDR  in  3  write destination
- wbData  in  16  write data
- idStall  out  1  combinational load-use stall request to fetch; fetch holds IR/NPC
- idValid  out  1  output bundle holds a real instruction
- idOp  out  4  opcode, IR[15:12]
- idOpA  out  16  SR1 value, IR[8:6]
- idOpB  out  16  SR2 value (IR[2:0]); for ST/STI/STR, the value of IR[11:9]
- idImm  out  16  selected immediate, sign-extended
- idDR  out  3  destination register (7 for JSR/JSRR)
- idRegWe  out  1  instruction writes a register
- idSetCC  out  1  instruction updates NZP
- idNPCout  out  16  registered idNPC

## Operation
- Register file: R0–R7 are cleared to 0 on reset. A write occurs on the clock edge when wbEn=1, regardless of pause, flush or stall.
- Bypass: a read of register r returns wbData in the same cycle when wbEn=1 and wbDR=r.
- Immediate select, by opcode:
  - ADD/AND: imm5 = IR[4:0]
  - LDR/STR: offset6 = IR[5:0]
  - BR/LD/LDI/ST/STI/LEA: PCoffset9 = IR[8:0]
  - JSR (IR[11]=1): PCoffset11 = IR[10:0]
  - TRAP: trapvect8 = IR[7:0], zero-extended
  - All other opcodes: 0
- idRegWe = 1 for ADD, AND, NOT, LD, LDR, LDI, LEA, JSR/JSRR.
- idSetCC = 1 for ADD, AND, NOT, LD, LDR, LDI.
- Load-use hazard: idStall = 1 when all of the following hold:
  - idValid = 1
  - the registered idOp is LD, LDR or LDI
  - the registered idDR equals a source actually used by the incoming IR:
    - SR1 for ADD, AND, NOT, LDR, STR, JMP, JSRR
    - SR2 for ADD/AND with IR[5]=0
    - IR[11:9] for ST, STI, STR
- Register update priority on each edge:
  1. reset=0: all outputs 0 (idValid=0, idStall=0).
  2. flush=1: bubble. idValid=0, idRegWe=0, idSetCC=0; other fields don't-care (driven 0).
  3. pause=1: hold everything.
  4. idStall=1: bubble, as in flush.
  5. Otherwise: latch the decode of idIR/idNPC and set idValid=1.
- idStall is gated to 0 while reset=0 or flush=1.

## Timing
- Latency: 1 cycle. Fields presented on idIR at edge N appear on outputs after edge N.
- Operand reads and bypass are combinational before the edge. A writeback in cycle N is visible to the instruction latched at edge N.
- A stall lasts exactly one cycle per load-use pair. The following cycle the registered op is a bubble, so idStall deasserts.
- flush overrides a simultaneous pause: bubble inserted.
- Reset mid-stall clears idStall in the same cycle it is asserted and clears all registers.

## Test plan
- Reset: hold reset=0 for 2 cycles with idIR=16'h1262 → all outputs 0, idValid=0. Read R1 → 16'h0000.
- Writeback bypass: wbEn=1, wbDR=3, wbData=16'h00A5 while idIR=16'h10C3 (ADD R0,R3,R3) → next cycle idOpA=idOpB=16'h00A5, idDR=0, idRegWe=1, idSetCC=1.
- Immediate sign-extension:
  - idIR=16'h1A7F (ADD R5,R1,#-1) → idImm=16'hFFFF.
  - idIR=16'h4FFF (JSR off11=-1) → idImm=16'hFFFF, idDR=7.
  - idIR=16'hF025 (TRAP x25) → idImm=16'h0025.
- Load-use: issue 16'h2401 (LD R2), then 16'h1282 (ADD R1,R2,R2) → idStall=1 for one cycle, bubble output (idValid=0), then the ADD is latched with idValid=1.
- Pause/flush: pause=1 for 3 cycles → outputs unchanged. pause=1 and flush=1 together → idValid=0 after the edge.
- Store source: R4=16'h1234 and idIR=16'h3805 (ST R4) → idOpB=16'h1234, idRegWe=0, idImm=16'h0005.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: LC-3 instruction-decode stage.
// Registers the fetched IR/NPC, decodes opcode, register and immediate
// fields, reads operands from an 8x16 register file with write-through
// bypass from writeback, and raises a load-use stall toward fetch.
// Ports:
//   clk, reset (sync, active-low), pause (hold outputs), flush (bubble)
//   idIR/idNPC      : instruction word and PC+1 from fetch
//   wbEn/wbDR/wbData: register-file write port
//   idStall         : combinational load-use stall to fetch
//   idValid, idOp, idOpA, idOpB, idImm, idDR, idRegWe, idSetCC, idNPCout:
//                     registered decode bundle to execute
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        flush,
  input  logic [15:0] idIR,
  input  logic [15:0] idNPC,
  input  logic        wbEn,
  input  logic [2:0]  wbDR,
  input  logic [15:0] wbData,
  output logic        idStall,
  output logic        idValid,
  output logic [3:0]  idOp,
  output logic [15:0] idOpA,
  output logic [15:0] idOpB,
  output logic [15:0] idImm,
  output logic [2:0]  idDR,
  output logic        idRegWe,
  output logic        idSetCC,
  output logic [15:0] idNPCout
);

  typedef enum logic [3:0] {
    OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
    OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
    OP_JMP = 4'hC, OP_RES = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
  } op_e;

  logic [15:0] r_rf [8];

  logic        r_valid;
  logic [3:0]  r_op;
  logic [15:0] r_opA;
  logic [15:0] r_opB;
  logic [15:0] r_imm;
  logic [2:0]  r_dr;
  logic        r_regWe;
  logic        r_setCC;
  logic [15:0] r_npc;

  op_e         w_op;
  logic [2:0]  w_sr1;
  logic [2:0]  w_sr2;
  logic        w_isStore;
  logic [15:0] w_rdA;
  logic [15:0] w_rdB;
  logic [15:0] w_imm;
  logic [2:0]  w_dr;
  logic        w_regWe;
  logic        w_setCC;
  logic        w_useSr1;
  logic        w_useSr2;
  logic        w_useSt;
  logic        w_ldPending;
  logic        w_hazard;

  assign w_op      = op_e'(idIR[15:12]);
  assign w_isStore = (w_op == OP_ST) || (w_op == OP_STI) || (w_op == OP_STR);
  assign w_sr1     = idIR[8:6];
  // Stores carry their data register in IR[11:9]; route it through port B.
  assign w_sr2     = w_isStore ? idIR[11:9] : idIR[2:0];

  assign w_rdA = (wbEn && (wbDR == w_sr1)) ? wbData : r_rf[w_sr1];
  assign w_rdB = (wbEn && (wbDR == w_sr2)) ? wbData : r_rf[w_sr2];

  always_comb begin
    w_imm    = '0;
    w_dr     = idIR[11:9];
    w_regWe  = 1'b0;
    w_setCC  = 1'b0;
    w_useSr1 = 1'b0;
    w_useSr2 = 1'b0;
    w_useSt  = 1'b0;
    case (w_op)
      OP_ADD, OP_AND: begin
        w_imm    = {{11{idIR[4]}}, idIR[4:0]};
        w_regWe  = 1'b1;
        w_setCC  = 1'b1;
        w_useSr1 = 1'b1;
        w_useSr2 = ~idIR[5];
      end
      OP_NOT: begin
        w_regWe  = 1'b1;
        w_setCC  = 1'b1;
        w_useSr1 = 1'b1;
      end
      OP_LD, OP_LDI: begin
        w_imm   = {{7{idIR[8]}}, idIR[8:0]};
        w_regWe = 1'b1;
        w_setCC = 1'b1;
      end
      OP_LDR: begin
        w_imm    = {{10{idIR[5]}}, idIR[5:0]};
        w_regWe  = 1'b1;
        w_setCC  = 1'b1;
        w_useSr1 = 1'b1;
      end
      OP_ST, OP_STI: begin
        w_imm   = {{7{idIR[8]}}, idIR[8:0]};
        w_useSt = 1'b1;
      end
      OP_STR: begin
        w_imm    = {{10{idIR[5]}}, idIR[5:0]};
        w_useSr1 = 1'b1;
        w_useSt  = 1'b1;
      end
      OP_BR: w_imm = {{7{idIR[8]}}, idIR[8:0]};
      OP_LEA: begin
        w_imm   = {{7{idIR[8]}}, idIR[8:0]};
        w_regWe = 1'b1;
      end
      OP_JSR: begin
        w_dr    = 3'd7;
        w_regWe = 1'b1;
        if (idIR[11]) w_imm    = {{5{idIR[10]}}, idIR[10:0]};
        else          w_useSr1 = 1'b1;
      end
      OP_JMP:  w_useSr1 = 1'b1;
      OP_TRAP: w_imm = {8'h00, idIR[7:0]};
      default: ;
    endcase
  end

  assign w_ldPending = r_valid &&
                       ((r_op == OP_LD) || (r_op == OP_LDR) || (r_op == OP_LDI));
  assign w_hazard    = w_ldPending &&
                       ((w_useSr1 && (r_dr == idIR[8:6])) ||
                        (w_useSr2 && (r_dr == idIR[2:0])) ||
                        (w_useSt  && (r_dr == idIR[11:9])));
  assign idStall     = w_hazard && reset && !flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (wbEn) begin
      r_rf[wbDR] <= wbData;
    end
  end

  // flush outranks pause; a stall bubble only lands when not paused.
  always_ff @(posedge clk) begin
    if (!reset || flush || (!pause && w_hazard)) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_imm   <= '0;
      r_dr    <= '0;
      r_regWe <= 1'b0;
      r_setCC <= 1'b0;
      r_npc   <= '0;
    end else if (!pause) begin
      r_valid <= 1'b1;
      r_op    <= idIR[15:12];
      r_opA   <= w_rdA;
      r_opB   <= w_rdB;
      r_imm   <= w_imm;
      r_dr    <= w_dr;
      r_regWe <= w_regWe;
      r_setCC <= w_setCC;
      r_npc   <= idNPC;
    end
  end

  assign idValid  = r_valid;
  assign idOp     = r_op;
  assign idOpA    = r_opA;
  assign idOpB    = r_opB;
  assign idImm    = r_imm;
  assign idDR     = r_dr;
  assign idRegWe  = r_regWe;
  assign idSetCC  = r_setCC;
  assign idNPCout = r_npc;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: each stimulus cycle queues the expected
// stall for that cycle and the expected registered bundle after the edge;
// a monitor pops and compares once per clock.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, pause, flush, wbEn;
  logic [15:0] idIR, idNPC, wbData;
  logic [2:0]  wbDR;
  logic        idStall, idValid, idRegWe, idSetCC;
  logic [3:0]  idOp;
  logic [15:0] idOpA, idOpB, idImm, idNPCout;
  logic [2:0]  idDR;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic        full;   // 0: bubble, only valid/regwe/setcc are compared
    logic        valid;
    logic [3:0]  op;
    logic [15:0] opa, opb, imm;
    logic [2:0]  dr;
    logic        we, cc;
    logic [15:0] npc;
    int          step;
  } exp_t;

  exp_t q[$];
  int   step_no = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .pause(pause), .flush(flush),
    .idIR(idIR), .idNPC(idNPC), .wbEn(wbEn), .wbDR(wbDR), .wbData(wbData),
    .idStall(idStall), .idValid(idValid), .idOp(idOp), .idOpA(idOpA),
    .idOpB(idOpB), .idImm(idImm), .idDR(idDR), .idRegWe(idRegWe),
    .idSetCC(idSetCC), .idNPCout(idNPCout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int stp, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step%0d %s: got %h expected %h", stp, nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic stall, input logic [3:0] op,
                              input logic [15:0] opa, opb, imm,
                              input logic [2:0] dr, input logic we, cc,
                              input logic [15:0] npc);
    exp_t e;
    e.stall = stall; e.full = 1'b1; e.valid = 1'b1; e.op = op;
    e.opa = opa; e.opb = opb; e.imm = imm; e.dr = dr;
    e.we = we; e.cc = cc; e.npc = npc; e.step = 0;
    return e;
  endfunction

  function automatic exp_t bub(input logic stall);
    exp_t e;
    e = mk(stall, 4'h0, '0, '0, '0, 3'd0, 1'b0, 1'b0, '0);
    e.full = 1'b0; e.valid = 1'b0;
    return e;
  endfunction

  function automatic exp_t zero_all();
    exp_t e;
    e = mk(1'b0, 4'h0, '0, '0, '0, 3'd0, 1'b0, 1'b0, '0);
    e.valid = 1'b0;
    return e;
  endfunction

  task automatic drive(input logic rst, ps, fl, input logic [15:0] ir, npc,
                       input logic we, input logic [2:0] wdr,
                       input logic [15:0] wd, input exp_t e);
    @(negedge clk);
    reset = rst; pause = ps; flush = fl; idIR = ir; idNPC = npc;
    wbEn = we; wbDR = wdr; wbData = wd;
    step_no++;
    e.step = step_no;
    q.push_back(e);
  endtask

  // Monitor: stall sampled mid-cycle, registered bundle just after the edge.
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      #2 s = idStall;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", e.step, {15'd0, s}, {15'd0, e.stall});
        chk("valid", e.step, {15'd0, idValid}, {15'd0, e.valid});
        chk("regwe", e.step, {15'd0, idRegWe}, {15'd0, e.we});
        chk("setcc", e.step, {15'd0, idSetCC}, {15'd0, e.cc});
        if (e.full) begin
          chk("op",  e.step, {12'd0, idOp}, {12'd0, e.op});
          chk("opA", e.step, idOpA, e.opa);
          chk("opB", e.step, idOpB, e.opb);
          chk("imm", e.step, idImm, e.imm);
          chk("dr",  e.step, {13'd0, idDR}, {13'd0, e.dr});
          chk("npc", e.step, idNPCout, e.npc);
        end
      end
    end
  end

  initial begin
    exp_t hold;
    reset = 1'b0; pause = 1'b0; flush = 1'b0; idIR = 16'h1262; idNPC = 16'h0010;
    wbEn = 1'b0; wbDR = 3'd0; wbData = '0;

    // reset held two cycles
    drive(0, 0, 0, 16'h1262, 16'h0010, 0, 0, 0, zero_all());
    drive(0, 0, 0, 16'h1262, 16'h0010, 0, 0, 0, zero_all());
    // ADD R0,R1,R2: R1 reads 0 after reset
    drive(1, 0, 0, 16'h1042, 16'h3001, 0, 0, 0,
          mk(0, 4'h1, 16'h0000, 16'h0000, 16'h0002, 3'd0, 1, 1, 16'h3001));
    // writeback bypass into ADD R0,R3,R3
    drive(1, 0, 0, 16'h10C3, 16'h3002, 1, 3'd3, 16'h00A5,
          mk(0, 4'h1, 16'h00A5, 16'h00A5, 16'h0003, 3'd0, 1, 1, 16'h3002));
    // ADD R5,R1,#-1
    drive(1, 0, 0, 16'h1A7F, 16'h3003, 0, 0, 0,
          mk(0, 4'h1, 16'h0000, 16'h0000, 16'hFFFF, 3'd5, 1, 1, 16'h3003));
    // JSR off11=-1
    drive(1, 0, 0, 16'h4FFF, 16'h3004, 0, 0, 0,
          mk(0, 4'h4, 16'h0000, 16'h0000, 16'hFFFF, 3'd7, 1, 0, 16'h3004));
    // TRAP x25, zero-extended
    drive(1, 0, 0, 16'hF025, 16'h3005, 0, 0, 0,
          mk(0, 4'hF, 16'h0000, 16'h0000, 16'h0025, 3'd0, 0, 0, 16'h3005));
    // R3 still holds A5 from the earlier writeback (read via SR1 of NOT R0,R3)
    drive(1, 0, 0, 16'h90FF, 16'h3006, 0, 0, 0,
          mk(0, 4'h9, 16'h00A5, 16'h0000, 16'h0000, 3'd0, 1, 1, 16'h3006));
    // LD R2 then ADD R1,R2,R2: one stall cycle, R2 written meanwhile
    drive(1, 0, 0, 16'h2401, 16'h3007, 0, 0, 0,
          mk(0, 4'h2, 16'h0000, 16'h0000, 16'h0001, 3'd2, 1, 1, 16'h3007));
    drive(1, 0, 0, 16'h1282, 16'h3008, 1, 3'd2, 16'h0777, bub(1));
    hold = mk(0, 4'h1, 16'h0777, 16'h0777, 16'h0002, 3'd1, 1, 1, 16'h3008);
    drive(1, 0, 0, 16'h1282, 16'h3008, 0, 0, 0, hold);
    // pause three cycles: bundle unchanged
    drive(1, 1, 0, 16'h5000, 16'h3009, 0, 0, 0, hold);
    drive(1, 1, 0, 16'h5000, 16'h3009, 0, 0, 0, hold);
    drive(1, 1, 0, 16'h5000, 16'h3009, 0, 0, 0, hold);
    // pause with flush: flush wins
    drive(1, 1, 1, 16'h5000, 16'h3009, 0, 0, 0, bub(0));
    // ST R4 with R4 bypassed in the same cycle
    drive(1, 0, 0, 16'h3805, 16'h300A, 1, 3'd4, 16'h1234,
          mk(0, 4'h3, 16'h0000, 16'h1234, 16'h0005, 3'd4, 0, 0, 16'h300A));
    // LDR R6 then STR using R6 as base, but flushed: no stall
    drive(1, 0, 0, 16'h6C40, 16'h300B, 0, 0, 0,
          mk(0, 4'h6, 16'h0000, 16'h0000, 16'h0000, 3'd6, 1, 1, 16'h300B));
    drive(1, 0, 1, 16'h7180, 16'h300C, 0, 0, 0, bub(0));
    // LDR R6 again, then reset during the would-be stall
    drive(1, 0, 0, 16'h6C40, 16'h300D, 0, 0, 0,
          mk(0, 4'h6, 16'h0000, 16'h0000, 16'h0000, 3'd6, 1, 1, 16'h300D));
    drive(0, 0, 0, 16'h7180, 16'h300E, 0, 0, 0, zero_all());
    // LDR R6 then STR R6 (data register IR[11:9]) stalls once
    drive(1, 0, 0, 16'h6C40, 16'h300F, 0, 0, 0,
          mk(0, 4'h6, 16'h0000, 16'h0000, 16'h0000, 3'd6, 1, 1, 16'h300F));
    drive(1, 0, 0, 16'h7C00, 16'h3010, 0, 0, 0, bub(1));
    drive(1, 0, 0, 16'h7C00, 16'h3010, 0, 0, 0,
          mk(0, 4'h7, 16'h0000, 16'h0000, 16'h0000, 3'd6, 0, 0, 16'h3010));
    // LD R2 then ADD with immediate whose low bits name R2: no stall
    drive(1, 0, 0, 16'h2401, 16'h3011, 0, 0, 0,
          mk(0, 4'h2, 16'h0000, 16'h0000, 16'h0001, 3'd2, 1, 1, 16'h3011));
    drive(1, 0, 0, 16'h1022, 16'h3012, 0, 0, 0,
          mk(0, 4'h1, 16'h0000, 16'h0000, 16'h0002, 3'd0, 1, 1, 16'h3012));
    // R3 was cleared by the mid-run reset
    drive(1, 0, 0, 16'h10C3, 16'h3013, 0, 0, 0,
          mk(0, 4'h1, 16'h0000, 16'h0000, 16'h0003, 3'd0, 1, 1, 16'h3013));

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
